// File: rtl/cpu_pkg.sv
// Shared types and constants for the 8-bit CPU sequencer.
package cpu_pkg;

   localparam int unsigned CPU_DATA_WIDTH = 8;
   localparam int unsigned CPU_ADDR_WIDTH = 4;
   localparam int unsigned ALU_OP_WIDTH   = 4;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      EXECUTE,
      WRITEBACK,
      HALTED
   } seq_state_t;

   // Instruction class lives in bits [7:6]
   localparam logic [1:0] CLS_ALU = 2'b00;
   localparam logic [1:0] CLS_JMP = 2'b01;
   localparam logic [1:0] CLS_JZ  = 2'b10;
   localparam logic [1:0] CLS_SYS = 2'b11;

   localparam logic [7:0] OPC_HALT = 8'hFF;

endpackage

// File: rtl/seq_pc.sv
// Program counter: clear, wrapping increment, jump load and end-of-program compare.
module seq_pc #(
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clr,
   input  logic                  inc,
   input  logic                  load,
   input  logic [ADDR_WIDTH-1:0] load_addr,
   input  logic [ADDR_WIDTH:0]   prog_len,
   input  logic                  prog_full,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic                  end_of_prog_c
);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         pc <= '0;
      end else if (load) begin
         pc <= load_addr;
      end else if (inc) begin
         pc <= pc + ADDR_WIDTH'(1);
      end
   end

   // A full program never runs off the end; only HALT stops it
   assign end_of_prog_c = !prog_full && ({1'b0, pc} >= prog_len);

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute controller: loads the program into instruction memory
// and sequences the PC, issuing ALU ops until HALT or end of program.
module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = CPU_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = CPU_ADDR_WIDTH
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    prog_wr,
   input  logic [DATA_WIDTH-1:0]   prog_data,
   input  logic                    prog_clr,
   input  logic                    start,
   output logic                    mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_waddr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic [ADDR_WIDTH-1:0]   mem_raddr,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   output logic                    alu_en,
   output logic [ALU_OP_WIDTH-1:0] alu_op,
   input  logic [DATA_WIDTH-1:0]   alu_y,
   output logic [ADDR_WIDTH-1:0]   pc,
   output logic [ADDR_WIDTH:0]     prog_len,
   output logic                    prog_full,
   output logic                    busy,
   output logic                    done,
   output logic                    result_valid,
   output logic [DATA_WIDTH-1:0]   result,
   output logic                    zero_flag,
   output logic                    load_err
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
   localparam int unsigned LEN_W = ADDR_WIDTH + 1;

   seq_state_t            state_q, state_d;
   logic [DATA_WIDTH-1:0] instr_q;
   logic [LEN_W-1:0]      prog_len_d;
   logic [1:0]            cls_c;
   logic                  idle_c;
   logic                  load_ok_c;
   logic                  pc_clr_c, pc_inc_c, pc_load_c;
   logic                  eop_c;

   assign idle_c    = (state_q == IDLE) || (state_q == HALTED);
   assign load_ok_c = idle_c && prog_wr && !prog_clr && !prog_full && !reset;
   assign cls_c     = instr_q[7:6];

   // Memory write port is combinational so the word lands on this edge
   assign mem_we    = load_ok_c;
   assign mem_waddr = load_ok_c ? prog_len[ADDR_WIDTH-1:0] : '0;
   assign mem_wdata = load_ok_c ? prog_data : '0;
   assign mem_raddr = pc;

   seq_pc #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_pc (
      .clk           (clk),
      .reset         (reset),
      .clr           (pc_clr_c),
      .inc           (pc_inc_c),
      .load          (pc_load_c),
      .load_addr     (instr_q[ADDR_WIDTH-1:0]),
      .prog_len      (prog_len),
      .prog_full     (prog_full),
      .pc            (pc),
      .end_of_prog_c (eop_c)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, PC control and ALU issue
   always_comb begin
      state_d   = state_q;
      pc_clr_c  = 1'b0;
      pc_inc_c  = 1'b0;
      pc_load_c = 1'b0;
      alu_en    = 1'b0;
      alu_op    = '0;
      case (state_q)
         IDLE, HALTED: begin
            if (start) begin
               state_d  = FETCH;
               pc_clr_c = 1'b1;
            end
         end
         FETCH:     state_d = eop_c ? HALTED : DECODE;
         DECODE:    state_d = EXECUTE;
         EXECUTE: begin
            state_d = FETCH;
            case (cls_c)
               CLS_ALU: begin
                  alu_en  = 1'b1;
                  alu_op  = instr_q[ALU_OP_WIDTH-1:0];
                  state_d = WRITEBACK;
               end
               CLS_JMP: pc_load_c = 1'b1;
               CLS_JZ: begin
                  pc_load_c = zero_flag;
                  pc_inc_c  = !zero_flag;
               end
               default: begin
                  if (instr_q[7:0] == OPC_HALT) begin
                     state_d = HALTED;
                  end else begin
                     pc_inc_c = 1'b1;
                  end
               end
            endcase
         end
         WRITEBACK: begin
            pc_inc_c = 1'b1;
            state_d  = FETCH;
         end
         default:   state_d = IDLE;
      endcase
   end

   // Load counter; clear wins over a write in the same cycle
   always_comb begin
      prog_len_d = prog_len;
      if (idle_c && prog_clr) begin
         prog_len_d = '0;
      end else if (load_ok_c) begin
         prog_len_d = prog_len + LEN_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prog_len     <= '0;
         prog_full    <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         result_valid <= 1'b0;
         result       <= '0;
         zero_flag    <= 1'b0;
         load_err     <= 1'b0;
         instr_q      <= '0;
      end else begin
         prog_len     <= prog_len_d;
         prog_full    <= (prog_len_d == LEN_W'(DEPTH));
         busy         <= !((state_d == IDLE) || (state_d == HALTED));
         done         <= (state_d == HALTED) && (state_q != HALTED);
         result_valid <= (state_q == WRITEBACK);
         load_err     <= prog_wr && (!idle_c || (prog_full && !prog_clr));
         if (state_q == DECODE) begin
            instr_q <= mem_rdata;
         end
         if (state_q == WRITEBACK) begin
            result    <= alu_y;
            zero_flag <= (alu_y == '0);
         end
      end
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: an ISA-level interpreter predicts result/done
// events with their cycle stamps; a negedge monitor pops and compares them.
module tb_cpu_sequencer;

   localparam int K_RES  = 0;
   localparam int K_DONE = 1;

   typedef struct {
      int kind;
      int cyc;
      int val;
      int zf;
   } ev_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       prog_wr;
   logic [7:0] prog_data;
   logic       prog_clr;
   logic       start;
   logic       mem_we;
   logic [3:0] mem_waddr;
   logic [7:0] mem_wdata;
   logic [3:0] mem_raddr;
   logic [7:0] mem_rdata;
   logic       alu_en;
   logic [3:0] alu_op;
   logic [7:0] alu_y;
   logic [3:0] pc;
   logic [4:0] prog_len;
   logic       prog_full;
   logic       busy;
   logic       done;
   logic       result_valid;
   logic [7:0] result;
   logic       zero_flag;
   logic       load_err;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   ev_t  sb[$];
   bit   lerr_exp[int];
   logic [7:0] mem [16];

   // Reference-model state: program image, length and zero flag
   logic [7:0] mprog [16];
   int   mlen  = 0;
   bit   mzero = 1'b0;

   cpu_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .prog_wr      (prog_wr),
      .prog_data    (prog_data),
      .prog_clr     (prog_clr),
      .start        (start),
      .mem_we       (mem_we),
      .mem_waddr    (mem_waddr),
      .mem_wdata    (mem_wdata),
      .mem_raddr    (mem_raddr),
      .mem_rdata    (mem_rdata),
      .alu_en       (alu_en),
      .alu_op       (alu_op),
      .alu_y        (alu_y),
      .pc           (pc),
      .prog_len     (prog_len),
      .prog_full    (prog_full),
      .busy         (busy),
      .done         (done),
      .result_valid (result_valid),
      .result       (result),
      .zero_flag    (zero_flag),
      .load_err     (load_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Instruction memory and ALU (echoes the op code), both one cycle
   always @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
      mem_rdata <= mem[mem_raddr];
      if (alu_en) alu_y <= {4'h0, alu_op};
   end

   function automatic void chk(input bit ok, input string nm, input int act, input int exp);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   function automatic void push(input int kind, input int c, input int val, input int zf);
      ev_t e;
      e.kind = kind; e.cyc = c; e.val = val; e.zf = zf;
      sb.push_back(e);
   endfunction

   // Monitor: compares every result/done/load_err the DUT presents
   always @(negedge clk) begin
      ev_t e;
      bit  le;
      if (cyc >= 1) begin
         if (result_valid === 1'b1) begin
            if (sb.size() == 0) chk(1'b0, "unexpected_result", int'(result), -1);
            else begin
               e = sb.pop_front();
               chk(e.kind == K_RES, "result_kind", K_RES, e.kind);
               chk(e.cyc == cyc, "result_cycle", cyc, e.cyc);
               chk(int'(result) == e.val, "result_value", int'(result), e.val);
               chk(int'(zero_flag) == e.zf, "zero_flag", int'(zero_flag), e.zf);
            end
         end
         if (done === 1'b1) begin
            if (sb.size() == 0) chk(1'b0, "unexpected_done", int'(pc), -1);
            else begin
               e = sb.pop_front();
               chk(e.kind == K_DONE, "done_kind", K_DONE, e.kind);
               chk(e.cyc == cyc, "done_cycle", cyc, e.cyc);
               chk(int'(pc) == e.val, "halt_pc", int'(pc), e.val);
            end
         end
         le = lerr_exp.exists(cyc);
         if (load_err === 1'b1 || le) chk(load_err === le, "load_err", int'(load_err), int'(le));
      end
   end

   initial begin
      repeat (60000) @(posedge clk);
      $display("FAIL watchdog: got %0d cycles expected under 60000", cyc);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ISA interpreter: start sampled at end of cycle s, first FETCH at s+1
   task automatic model_run(input int s, input int limit, output bit halted, output int hcyc);
      int t  = s + 1;
      int mp = 0;
      int y;
      logic [7:0] w;
      halted = 1'b0;
      hcyc   = 0;
      while (t <= limit) begin
         if (mlen < 16 && mp >= mlen) begin halted = 1'b1; hcyc = t + 1; break; end
         w = mprog[mp];
         case (w[7:6])
            2'b00: begin
               y = int'(w[3:0]);
               if (t + 4 <= limit) push(K_RES, t + 4, y, int'(y == 0));
               mzero = (y == 0);
               mp = (mp + 1) % 16;
               t += 4;
            end
            2'b01: begin mp = int'(w[3:0]); t += 3; end
            2'b10: begin mp = mzero ? int'(w[3:0]) : (mp + 1) % 16; t += 3; end
            default: begin
               if (w == 8'hFF) begin halted = 1'b1; hcyc = t + 3; break; end
               mp = (mp + 1) % 16;
               t += 3;
            end
         endcase
      end
      if (halted && hcyc > limit) halted = 1'b0;
      if (halted) push(K_DONE, hcyc, mp, 0);
   endtask

   task automatic clear_prog();
      prog_clr = 1'b1;
      step();
      prog_clr = 1'b0;
      mlen = 0;
      chk(prog_len == 5'd0, "clr_len", int'(prog_len), 0);
   endtask

   task automatic load_word(input logic [7:0] w);
      prog_wr = 1'b1;
      prog_data = w;
      #1;
      if (mlen < 16) begin
         chk(mem_we === 1'b1 && int'(mem_waddr) == mlen && mem_wdata == w, "load_port",
             int'({mem_we, mem_waddr}), 16 + mlen);
         mprog[mlen] = w;
         mlen++;
      end else begin
         chk(mem_we === 1'b0, "full_we", int'(mem_we), 0);
         lerr_exp[cyc + 1] = 1'b1;
      end
      step();
      prog_wr = 1'b0;
   endtask

   task automatic check_len();
      chk(int'(prog_len) == mlen, "prog_len", int'(prog_len), mlen);
      chk(prog_full == (mlen == 16), "prog_full", int'(prog_full), int'(mlen == 16));
   endtask

   // Start a run; optional write in the start cycle; junk prog_wr/start while busy
   task automatic run_prog(input int budget, input bit junk, input bit wr_last, input logic [7:0] wl);
      int s, limit, end_c, hcyc;
      bit halted;
      s = cyc;
      if (wr_last && mlen < 16) begin
         prog_wr = 1'b1; prog_data = wl;
         mprog[mlen] = wl; mlen++;
      end
      start = 1'b1;
      limit = s + budget;
      model_run(s, limit, halted, hcyc);
      step();
      start = 1'b0; prog_wr = 1'b0;
      end_c = halted ? hcyc : limit;
      while (cyc < end_c) begin
         if (junk && $urandom_range(0, 3) == 0) begin
            prog_wr = 1'b1; start = 1'b1; prog_data = 8'($urandom);
            lerr_exp[cyc + 1] = 1'b1;
            #1;
            chk(mem_we === 1'b0, "busy_we", int'(mem_we), 0);
         end
         step();
         prog_wr = 1'b0; start = 1'b0;
      end
      if (halted) begin
         step();
         chk(busy === 1'b0, "halt_busy", int'(busy), 0);
         chk(done === 1'b0, "done_once", int'(done), 0);
      end else begin
         reset = 1'b1;
         step();
         reset = 1'b0;
         mzero = 1'b0; mlen = 0;
         chk(busy === 1'b0, "rst_busy", int'(busy), 0);
         chk(pc == 4'd0, "rst_pc", int'(pc), 0);
         chk(prog_len == 5'd0, "rst_len", int'(prog_len), 0);
         chk(result_valid === 1'b0, "rst_rv", int'(result_valid), 0);
         chk(zero_flag === 1'b0, "rst_zf", int'(zero_flag), 0);
      end
   endtask

   function automatic logic [7:0] rand_instr();
      int k = $urandom_range(0, 99);
      logic [7:0] w;
      if (k < 40)      w = {2'b00, 6'($urandom)};
      else if (k < 55) w = {2'b01, 6'($urandom)};
      else if (k < 70) w = {2'b10, 6'($urandom)};
      else if (k < 85) begin
         w = {2'b11, 6'($urandom)};
         if (w == 8'hFF) w = 8'hC0;
      end else         w = 8'hFF;
      return w;
   endfunction

   initial begin
      int n;
      bit wl;
      reset = 1'b1; prog_wr = 1'b0; prog_clr = 1'b0; start = 1'b0; prog_data = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      chk(busy === 1'b0, "reset_busy", int'(busy), 0);
      chk(pc === 4'd0, "reset_pc", int'(pc), 0);
      chk(prog_len === 5'd0, "reset_len", int'(prog_len), 0);
      chk(result === 8'd0, "reset_result", int'(result), 0);
      chk(zero_flag === 1'b0, "reset_zf", int'(zero_flag), 0);
      chk(mem_we === 1'b0 && alu_en === 1'b0, "reset_strobes", int'({mem_we, alu_en}), 0);
      chk(done === 1'b0 && result_valid === 1'b0, "reset_pulses", int'({done, result_valid}), 0);

      // Three ALU ops then end of program
      clear_prog();
      load_word(8'h00); load_word(8'h01); load_word(8'h02);
      check_len();
      run_prog(200, 1'b0, 1'b0, 8'h00);

      // JMP 1 then HALT, with junk writes/starts while busy
      clear_prog();
      load_word(8'h41); load_word(8'hFF);
      run_prog(200, 1'b1, 1'b0, 8'h00);

      // Full program of NOPs, overflow write, endless wrap until reset
      clear_prog();
      for (int i = 0; i < 16; i++) load_word(8'hC0);
      check_len();
      load_word(8'hC0);
      check_len();
      run_prog(100, 1'b1, 1'b0, 8'h00);

      // JZ taken after a zero ALU result
      clear_prog();
      load_word(8'h00); load_word(8'h83); load_word(8'hC0); load_word(8'hFF);
      run_prog(200, 1'b1, 1'b0, 8'h00);

      // Reset during EXECUTE of an ALU instruction
      clear_prog();
      load_word(8'h05);
      run_prog(3, 1'b0, 1'b0, 8'h00);

      // Randomized programs
      for (int r = 0; r < 30; r++) begin
         clear_prog();
         n  = $urandom_range(1, 16);
         wl = ($urandom_range(0, 3) == 0);
         for (int i = 0; i < (wl ? n - 1 : n); i++) load_word(rand_instr());
         if (!wl && n == 16 && $urandom_range(0, 1) == 1) load_word(rand_instr());
         check_len();
         run_prog(150, 1'b1, wl, rand_instr());
      end

      repeat (3) step();
      chk(sb.size() == 0, "sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
